// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads both sources from the register file and resolves
// them against the in-flight MEM and WB writes. It detects load-use hazards and
// loads the result into the ID/EX pipeline register that feeds the ALU.
module operand_fetch_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [REG_W-1:0]  id_dst,
    input  logic              id_wen,
    input  logic              id_is_load,
    output logic [REG_W-1:0]  rf_src1,
    output logic [REG_W-1:0]  rf_src2,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              mem_wen,
    input  logic [REG_W-1:0]  mem_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wen,
    input  logic [REG_W-1:0]  wb_dst,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic [REG_W-1:0]  ex_dst,
    output logic              ex_wen,
    output logic              ex_is_load
);

    // The two sources are handled identically, so they are packed into
    // index-addressable vectors and resolved by a single generate loop.
    logic [1:0][REG_W-1:0]  srcVec;
    logic [1:0]             useVec;
    logic [1:0][DATA_W-1:0] rfDataVec;
    logic [1:0][DATA_W-1:0] opSel;
    logic [1:0]             memHit;
    logic [1:0]             wbHit;
    logic [1:0]             exDepHit;

    // ID/EX register state
    logic              exValidReg;
    logic [DATA_W-1:0] exOp1Reg;
    logic [DATA_W-1:0] exOp2Reg;
    logic [REG_W-1:0]  exDstReg;
    logic              exWenReg;
    logic              exIsLoadReg;

    logic loadUse;

    assign srcVec    = {id_src2, id_src1};
    assign useVec    = {id_use2, id_use1};
    assign rfDataVec = {rf_data2, rf_data1};

    // The register file is addressed directly by the decoded source ids.
    assign rf_src1 = id_src1;
    assign rf_src2 = id_src2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // The file writes at the clock edge, so a same-cycle read returns
            // the old value. WB must therefore be bypassed. MEM holds the
            // younger value and wins when both target the same register.
            assign memHit[gi] = mem_wen && (mem_dst == srcVec[gi]);
            assign wbHit[gi]  = wb_wen  && (wb_dst  == srcVec[gi]);
            assign opSel[gi]  = memHit[gi] ? mem_data :
                                wbHit[gi]  ? wb_data  :
                                             rfDataVec[gi];

            // An unused source never depends on the instruction in EX.
            assign exDepHit[gi] = useVec[gi] && (srcVec[gi] == exDstReg);
        end
    endgenerate

    // Load-use: the load in EX has no data until it reaches MEM, so the
    // dependent instruction waits one cycle and then forwards from MEM.
    assign loadUse = exValidReg && exIsLoadReg && exWenReg && id_valid && (|exDepHit);

    // A flush squashes the stalled instruction, so no stall is needed then.
    assign id_stall = ex_hold || (loadUse && !flush);

    // ID/EX register update: reset, flush bubble, hold, load-use bubble, capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            exValidReg  <= 1'b0;
            exOp1Reg    <= '0;
            exOp2Reg    <= '0;
            exDstReg    <= '0;
            exWenReg    <= 1'b0;
            exIsLoadReg <= 1'b0;
        end else if (flush) begin
            // The back end still accepts a bubble while frozen, so flush
            // takes priority over the hold.
            exValidReg  <= 1'b0;
            exWenReg    <= 1'b0;
            exIsLoadReg <= 1'b0;
        end else if (ex_hold) begin
            exValidReg  <= exValidReg;
        end else if (loadUse) begin
            exValidReg  <= 1'b0;
            exWenReg    <= 1'b0;
            exIsLoadReg <= 1'b0;
        end else begin
            exValidReg  <= id_valid;
            exOp1Reg    <= opSel[0];
            exOp2Reg    <= opSel[1];
            exDstReg    <= id_dst;
            exWenReg    <= id_wen && id_valid;
            exIsLoadReg <= id_is_load && id_valid;
        end
    end

    assign ex_valid   = exValidReg;
    assign ex_op1     = exOp1Reg;
    assign ex_op2     = exOp2Reg;
    assign ex_dst     = exDstReg;
    assign ex_wen     = exWenReg;
    assign ex_is_load = exIsLoadReg;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-side consumer of the 16x16 register file.
- Drives the file's two read addresses and takes its combinational read data.
- Resolves operands against in-flight MEM and WB writes, and detects load-use hazards.
- Latches the result into the ID/EX pipeline register feeding the ALU.

Parameters:
- DATA_W, 16, operand/data width
- REG_W, 4, register address width (16 registers; R0 is an ordinary writable register)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous active-high reset
- id_valid  input  1  decoded instruction present in ID
- id_src1, id_src2  input  REG_W  source register ids
- id_use1, id_use2  input  1  instruction actually reads src1/src2
- id_dst  input  REG_W  destination id
- id_wen  input  1  instruction writes id_dst
- id_is_load  input  1  instruction is a load
- rf_src1, rf_src2  output  REG_W  read addresses to register file (combinational = id_src1/id_src2)
- rf_data1, rf_data2  input  DATA_W  register file read data
- mem_wen, mem_dst, mem_data  input  1/REG_W/DATA_W  instruction in MEM: write-enable, dest, result (load data valid same cycle)
- wb_wen, wb_dst, wb_data  input  1/REG_W/DATA_W  WB write; same signals drive the file's WriteReg/DstReg/DstData
- flush  input  1  squash ID instruction (branch taken)
- ex_hold  input  1  back end frozen; ID/EX register must hold
- id_stall  output  1  freeze PC and IF/ID this cycle
- ex_valid, ex_op1, ex_op2, ex_dst, ex_wen, ex_is_load  output  1/DATA_W/DATA_W/REG_W/1/1  ID/EX register contents

Behaviour:
- Reset (rst high at edge): every ex_* output is 0. id_stall is combinational and reads 0 while the registers are 0 and ex_hold is 0.
- Operand select per source n (combinational), highest priority first:
  1. mem_wen && mem_dst==id_srcn -> mem_data
  2. wb_wen && wb_dst==id_srcn -> wb_data. This bypass is required because the file writes at the edge, so a same-cycle read returns the old value.
  3. otherwise rf_datan
- Unused sources (id_usen=0) never forward and never cause hazards. Their operand value is don't-care but must be deterministic; use the select result.
- Load-use hazard, lu = ex_valid && ex_is_load && ex_wen && id_valid && ((id_use1 && id_src1==ex_dst) || (id_use2 && id_src2==ex_dst)).
- id_stall = ex_hold || (lu && !flush).
- ID/EX update at each rising edge, priority order:
  1. rst: clear all.
  2. flush: ex_valid<=0, ex_wen<=0, ex_is_load<=0. Other fields are don't-care. Flush wins over ex_hold, because the back end still accepts the bubble.
  3. ex_hold: all ex_* hold their value.
  4. lu: insert bubble (ex_valid<=0, ex_wen<=0, ex_is_load<=0). The ID instruction is re-presented next cycle and then forwards from MEM.
  5. otherwise: capture id_valid, selected operands, id_dst, id_wen&id_valid, id_is_load&id_valid.
- Latency: operands are visible on ex_* 1 cycle after ID presentation, or 2 cycles after a load-use bubble.
- id_valid=0 captures a bubble (ex_valid=0, ex_wen=0).
- Load-use stall lasts exactly 1 cycle per hazard. A back-to-back dependent pair behind one load produces one bubble only.
- MEM and WB writing the same register: MEM wins (younger value).
- Reset asserted mid-stall or mid-hold clears everything. id_stall then falls to 0 the next cycle unless ex_hold is high.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero inputs -> all ex_* = 0, id_stall = 0.
- Plain read: rf_data1=0x3099 (R7), id_src1=7, id_use1=1, no MEM/WB match -> next cycle ex_op1=0x3099, ex_valid=1.
- WB bypass: wb_wen=1, wb_dst=0, wb_data=0x808A, rf_data2=old 0x0000, id_src2=0 -> ex_op2=0x808A.
- MEM priority: mem_wen=1, mem_dst=3, mem_data=0xA173 and wb_wen=1, wb_dst=3, wb_data=0x1111, id_src1=3 -> ex_op1=0xA173.
- Load-use: EX holds load to R5; ID reads R5 -> id_stall=1 for one cycle, ex_valid=0 bubble. Next cycle mem_data=0xBEEF, mem_dst=5 -> ex_op1=0xBEEF, ex_valid=1.
- Hold vs flush:
  - ex_hold=1 for 3 cycles -> ex_* unchanged, id_stall=1.
  - flush=1 with ex_hold=1 -> ex_valid=0 next cycle.
  - A load-use hazard plus flush -> no stall, bubble.
